// File: rtl/lisp_pkg.sv
// Shared lisp-machine memory constants and arbiter types.
package lisp;

  localparam int addr_width  = 16;
  localparam int data_width  = 16;
  localparam int num_mem_req = 2;

  typedef enum logic [1:0] {
    ARB_BOOT  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_ERROR = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// One-hot requester select: round-robin with a pointer register when MEM_ARB_RR_EN
// is defined, fixed priority (lowest index wins) otherwise.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
`ifdef MEM_ARB_RR_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  import lisp::*;

  logic [IW-1:0] w_base;
  logic [IW:0]   w_cand;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] r_ptr;

  // Pointer holds the index the next search starts from; moves only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_idx == IW'(NUM_REQ - 1)) ? '0 : o_idx + IW'(1);
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, w_base} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IW+1)'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i_en && !o_any && i_req[j] && (w_cand == (IW+1)'(j))) begin
          o_gnt[j] = 1'b1;
          o_idx    = IW'(j);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among NUM_REQ requesters with boot gating, sticky error
// and fixed-latency read return. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int ADDR_WIDTH = lisp::addr_width,
  parameter int DATA_WIDTH = lisp::data_width,
  parameter int NUM_REQ    = lisp::num_mem_req,
  parameter int READ_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          boot_done,
  input  logic                          mem_error,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ready,
  output logic                          error
);
  import lisp::*;

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_BOOT  = ARB_BOOT;
  localparam logic [1:0] S_RUN   = ARB_RUN;
  localparam logic [1:0] S_ERROR = ARB_ERROR;

  logic [1:0]                     r_state;
  logic [ADDR_WIDTH-1:0]          r_mem_addr;
  logic                           r_mem_we;
  logic [DATA_WIDTH-1:0]          r_mem_wdata;
  logic [READ_LAT-1:0]            r_pv;
  logic [READ_LAT-1:0][IW-1:0]    r_po;

  logic                           w_run;
  logic                           w_en;
  logic                           w_any;
  logic [IW-1:0]                  w_idx;
  logic [NUM_REQ-1:0]             w_gnt;
  logic                           w_win_we;
  logic [ADDR_WIDTH-1:0]          w_win_addr;
  logic [DATA_WIDTH-1:0]          w_win_wdata;

  assign w_run = (r_state == S_RUN);
  // mem_error suppresses any grant in the cycle it appears, not just after.
  assign w_en  = w_run && !mem_error;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .i_en    (w_en),
    .i_req   (req),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign gnt = w_gnt;

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_win_we    = we[i];
        w_win_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ERROR is terminal until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else if (mem_error) begin
      r_state <= S_ERROR;
    end else if ((r_state == S_BOOT) && boot_done) begin
      r_state <= S_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_any && w_win_we;
      if (w_any) begin
        r_mem_addr  <= w_win_addr;
        r_mem_wdata <= w_win_wdata;
      end
    end
  end

  // Read-return pipe of {valid, owner}; an error drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_po <= '0;
    end else if (mem_error) begin
      r_pv <= '0;
      r_po <= '0;
    end else begin
      r_pv[0] <= w_any && !w_win_we;
      r_po[0] <= w_idx;
      for (int s = 1; s < READ_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_po[s] <= r_po[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_run && !mem_error && r_pv[READ_LAT-1] && (r_po[READ_LAT-1] == IW'(i))) begin
        rvalid[i] = 1'b1;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = mem_rdata;
  assign ready     = w_run;
  assign error     = (r_state == S_ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle registered memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic        mem_error;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [15:0] rdata;
  logic        ready;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .boot_done (boot_done),
    .mem_error (mem_error),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ready     (ready),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Memory model: address registered by the DUT at T+1, data presented at T+2.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'h0002;
      mem[8'h20] <= 16'h1234;
      mem[8'h21] <= 16'h5678;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; boot_done = 1'b0; mem_error = 1'b0;
    req = 2'b00; we = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
  endtask

  task automatic test_boot_gating();
    rst = 1'b0;
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0010;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL boot_gnt cycle %0d: got %b want 00", c, gnt); end
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL boot_ready cycle %0d: got %b want 0", c, ready); end
    end
    boot_done = 1'b1;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL boot_ready_up: got %b want 1", ready); end
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL boot_first_gnt: got %b want 01", gnt); end
    step(); req = 2'b00;
    step();
    step();
  endtask

  task automatic test_single_read();
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0010;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rd_gnt: got %b want 01", gnt); end
    step(); req = 2'b00; #1;
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL rd_mem_addr: got %h want 0010", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_mem_we: got %b want 0", mem_we); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_rvalid_early: got %b want 00", rvalid); end
    step();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rd_rvalid: got %b want 01", rvalid); end
    checks++; if (rdata !== 16'h0002) begin errors++; $display("[TB] FAIL rd_rdata: got %h want 0002", rdata); end
    step();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_rvalid_after: got %b want 00", rvalid); end
  endtask

  task automatic test_write_then_read();
    step();
    req = 2'b10; we = 2'b10; addr[31:16] = 16'h0040; wdata[31:16] = 16'hBEEF;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL wr_gnt: got %b want 10", gnt); end
    step();
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0040;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL wr_rd_gnt: got %b want 01", gnt); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_mem_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL wr_mem_addr: got %h want 0040", mem_addr); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_mem_wdata: got %h want beef", mem_wdata); end
    step(); req = 2'b00;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_mem_we_pulse: got %b want 0", mem_we); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL wr_no_rvalid: got %b want 00", rvalid); end
    step();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL raw_rvalid: got %b want 01", rvalid); end
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL raw_rdata: got %h want beef", rdata); end
    step();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL raw_rvalid_after: got %b want 00", rvalid); end
  endtask

  task automatic test_pipelined_reads();
    step();
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0020;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL pipe_gnt0: got %b want 01", gnt); end
    step();
    addr[15:0] = 16'h0021;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL pipe_gnt1: got %b want 01", gnt); end
    step(); req = 2'b00; #1;
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL pipe_rvalid0: got %b want 01", rvalid); end
    checks++; if (rdata !== 16'h1234) begin errors++; $display("[TB] FAIL pipe_rdata0: got %h want 1234", rdata); end
    step();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL pipe_rvalid1: got %b want 01", rvalid); end
    checks++; if (rdata !== 16'h5678) begin errors++; $display("[TB] FAIL pipe_rdata1: got %h want 5678", rdata); end
    step();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL pipe_rvalid_after: got %b want 00", rvalid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [6];
`ifdef MEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    step(); rst = 1'b1; req = 2'b00;
    step(); rst = 1'b0;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL cont_ready: got %b want 1", ready); end
    req = 2'b11; we = 2'b00; addr = {16'h0021, 16'h0020};
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (gnt !== exp_g[i]) begin errors++; $display("[TB] FAIL cont_gnt cycle %0d: got %b want %b", i, gnt, exp_g[i]); end
      if (i >= 2) begin
        checks++; if (rvalid !== exp_g[i-2]) begin errors++; $display("[TB] FAIL cont_rvalid cycle %0d: got %b want %b", i, rvalid, exp_g[i-2]); end
      end
      step();
    end
    req = 2'b00; #1;
    checks++; if (rvalid !== exp_g[4]) begin errors++; $display("[TB] FAIL cont_rvalid_tail0: got %b want %b", rvalid, exp_g[4]); end
    step();
    checks++; if (rvalid !== exp_g[5]) begin errors++; $display("[TB] FAIL cont_rvalid_tail1: got %b want %b", rvalid, exp_g[5]); end
    step();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL cont_rvalid_drain: got %b want 00", rvalid); end
  endtask

  task automatic test_error();
    step();
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0020;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL err_pre_gnt: got %b want 01", gnt); end
    step();
    mem_error = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL err_gnt_priority: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL err_rvalid_same: got %b want 00", rvalid); end
    step();
    mem_error = 1'b0;
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", error); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL err_ready: got %b want 0", ready); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL err_gnt: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL err_flush_rvalid: got %b want 00", rvalid); end
    step();
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky_later: got %b want 1", error); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL err_gnt_later: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL err_rvalid_later: got %b want 00", rvalid); end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    step(); rst = 1'b1;
    step();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL rst_clears_error: got %b want 0", error); end
    rst = 1'b0;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_reboot_ready: got %b want 1", ready); end
    req = 2'b01; we = 2'b00; addr[15:0] = 16'h0020;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL mid_rd_gnt: got %b want 01", gnt); end
    step();
    req = 2'b10; we = 2'b10; addr[31:16] = 16'h0050; wdata[31:16] = 16'h00AA;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL mid_wr_gnt: got %b want 10", gnt); end
    step();
    req = 2'b00; we = 2'b00;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_mem_we: got %b want 1", mem_we); end
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL mid_rvalid: got %b want 01", rvalid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL async_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL async_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL async_mem_wdata: got %h want 0000", mem_wdata); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL async_rvalid: got %b want 00", rvalid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL async_ready: got %b want 0", ready); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL async_gnt: got %b want 00", gnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL async_error: got %b want 0", error); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_boot: got %b want 0", ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL post_rst_rvalid cycle %0d: got %b want 00", c, rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_boot_gating();
    test_single_read();
    test_write_then_read();
    test_pipelined_reads();
    test_contention();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
